// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer.
//   src_e      - redirect source, enumerated in ascending priority order
//   src_prio() - numeric priority of a source (higher wins)
//   DEF_*      - default reset/exception vectors and sequential increment
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ = 3'd0,
        SRC_BR  = 3'd1,
        SRC_J   = 3'd2,
        SRC_JR  = 3'd3,
        SRC_EXC = 3'd4
    } src_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
    localparam int unsigned DEF_INC          = 4;

    function automatic int unsigned src_prio(input src_e s);
        int unsigned p;
        case (s)
            SRC_EXC: p = 4;
            SRC_JR:  p = 3;
            SRC_J:   p = 2;
            SRC_BR:  p = 1;
            default: p = 0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect request that arrived while the pipeline was stalled.
//   clock, reset_n - clock and asynchronous active-low reset
//   stall_i        - capture requests while high; pending entry is consumed when low
//   flush_i        - discard any pending entry (exception)
//   src_i/target_i - live redirect source (SRC_SEQ = none) and destination
//   valid_o        - a pending redirect is held
//   src_o/target_o - pending redirect source and destination
module pc_redirect_latch
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  src_e             src_i,
    input  logic [WIDTH-1:0] target_i,
    output logic             valid_o,
    output src_e             src_o,
    output logic [WIDTH-1:0] target_o
);

    logic             valid_q, valid_d;
    src_e             src_q, src_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;

    always_comb begin
        valid_d = valid_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        if (flush_i || !stall_i) begin
            // Unstalled cycle consumes the entry; exception discards it.
            valid_d = 1'b0;
            src_d   = SRC_SEQ;
            tgt_d   = '0;
        end else if (src_i != SRC_SEQ &&
                     (!valid_q || src_prio(src_i) >= src_prio(src_q))) begin
            // Equal priority replaces: the most recent request of a class wins.
            valid_d = 1'b1;
            src_d   = src_i;
            tgt_d   = target_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            src_q   <= SRC_SEQ;
            tgt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
        end
    end

    assign valid_o  = valid_q;
    assign src_o    = src_q;
    assign target_o = tgt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with prioritised redirects, stall-time redirect
// capture, exception override and misaligned-target trapping.
//   clock, reset_n            - clock and asynchronous active-low reset
//   stall                     - hold pc this cycle
//   branch_taken/branch_target, jump/jump_address, jr/jr_target
//                             - redirect requests and destinations
//   exception                 - force pc to EXC_VECTOR (overrides stall)
//   pc                        - registered program counter
//   pc_plus_inc               - combinational pc + INC (wraps)
//   redirect_pending          - a redirect captured during stall is waiting
//   misaligned                - one-cycle pulse: a misaligned target was trapped
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned      INC          = DEF_INC
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_address,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exception,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             redirect_pending,
    output logic             misaligned
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             misaligned_q, misaligned_d;

    src_e             live_src;
    logic [WIDTH-1:0] live_tgt;
    logic             pend_valid;
    src_e             pend_src;
    logic [WIDTH-1:0] pend_tgt;

    logic             redirect;
    logic [WIDTH-1:0] sel_tgt;

    assign pc_plus_inc = pc_q + WIDTH'(INC);

    // Highest-priority live redirect; exception is handled separately because
    // it is never deferred.
    always_comb begin
        live_src = SRC_SEQ;
        live_tgt = '0;
        if (jr) begin
            live_src = SRC_JR;
            live_tgt = jr_target;
        end else if (jump) begin
            live_src = SRC_J;
            live_tgt = jump_address;
        end else if (branch_taken) begin
            live_src = SRC_BR;
            live_tgt = branch_target;
        end
    end

    pc_redirect_latch #(
        .WIDTH (WIDTH)
    ) u_latch (
        .clock    (clock),
        .reset_n  (reset_n),
        .stall_i  (stall),
        .flush_i  (exception),
        .src_i    (live_src),
        .target_i (live_tgt),
        .valid_o  (pend_valid),
        .src_o    (pend_src),
        .target_o (pend_tgt)
    );

    always_comb begin
        redirect     = 1'b0;
        sel_tgt      = pc_plus_inc;
        pc_d         = pc_q;
        misaligned_d = 1'b0;

        // A live request always beats a pending one.
        if (live_src != SRC_SEQ) begin
            redirect = 1'b1;
            sel_tgt  = live_tgt;
        end else if (pend_valid && pend_src != SRC_SEQ) begin
            redirect = 1'b1;
            sel_tgt  = pend_tgt;
        end

        if (exception) begin
            pc_d = EXC_VECTOR;
        end else if (!stall) begin
            if (redirect && sel_tgt[1:0] != 2'b00) begin
                pc_d         = EXC_VECTOR;
                misaligned_d = 1'b1;
            end else begin
                pc_d = sel_tgt;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = pend_valid;
    assign misaligned       = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall, branch_taken, jump, jr, exception;
    logic [31:0] branch_target, jump_address, jr_target;
    logic [31:0] pc, pc_plus_inc;
    logic        redirect_pending, misaligned;

    int passed = 0;
    int total  = 0;

    pc_sequencer dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_address     (jump_address),
        .jr               (jr),
        .jr_target        (jr_target),
        .exception        (exception),
        .pc               (pc),
        .pc_plus_inc      (pc_plus_inc),
        .redirect_pending (redirect_pending),
        .misaligned       (misaligned)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; jr = 0; exception = 0;
        branch_target = '0; jump_address = '0; jr_target = '0;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pend", {31'b0, redirect_pending}, 32'h0);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);
        chk("rst_inc", pc_plus_inc, 32'h4);
        reset_n = 1'b1;

        // Sequential run after reset release
        step(); chk("seq1", pc, 32'h4);
        step(); chk("seq2", pc, 32'h8);
        step(); chk("seq3", pc, 32'hC);
        step(); chk("seq4", pc, 32'h10);

        // Jump beats branch
        jump = 1; jump_address = 32'd1012; branch_taken = 1; branch_target = 32'd44;
        step(); chk("jmp_over_br", pc, 32'd1012);
        chk("jmp_inc", pc_plus_inc, 32'd1016);
        idle();

        branch_taken = 1; branch_target = 32'd44;
        step(); chk("branch", pc, 32'd44);
        idle();

        jr = 1; jr_target = 32'h200; jump = 1; jump_address = 32'h300;
        branch_taken = 1; branch_target = 32'h400;
        step(); chk("jr_prio", pc, 32'h200);

        exception = 1;
        step(); chk("exc_over_jr", pc, 32'h80);
        idle();

        // Stall: jump captured, lower-priority branch ignored
        stall = 1; jump = 1; jump_address = 32'd1012;
        step(); chk("stall1_pc", pc, 32'h80);
        chk("stall1_pend", {31'b0, redirect_pending}, 32'h1);
        jump = 0; branch_taken = 1; branch_target = 32'd44;
        step(); chk("stall2_pc", pc, 32'h80);
        branch_taken = 0;
        step(); chk("stall3_pc", pc, 32'h80);
        chk("stall3_pend", {31'b0, redirect_pending}, 32'h1);
        stall = 0;
        step(); chk("stall_rel_pc", pc, 32'd1012);
        chk("stall_rel_pend", {31'b0, redirect_pending}, 32'h0);
        step(); chk("after_pend", pc, 32'd1016);

        // Higher-priority request replaces pending one
        stall = 1; branch_taken = 1; branch_target = 32'h100;
        step();
        branch_taken = 0; jump = 1; jump_address = 32'h200;
        step(); chk("repl_hold", pc, 32'd1016);
        idle();
        step(); chk("repl_pc", pc, 32'h200);

        // Exception during stall clears pending
        stall = 1; jump = 1; jump_address = 32'd1012;
        step(); chk("exc_pend_set", {31'b0, redirect_pending}, 32'h1);
        jump = 0; exception = 1;
        step(); chk("exc_stall_pc", pc, 32'h80);
        chk("exc_stall_pend", {31'b0, redirect_pending}, 32'h0);
        idle();
        step(); chk("exc_discard", pc, 32'h84);

        // Misaligned live jr target
        jr = 1; jr_target = 32'h1002;
        step(); chk("mis_jr_pc", pc, 32'h80);
        chk("mis_jr_flag", {31'b0, misaligned}, 32'h1);
        idle();
        step(); chk("mis_clr_pc", pc, 32'h84);
        chk("mis_clr_flag", {31'b0, misaligned}, 32'h0);

        // Misaligned pending branch target
        stall = 1; branch_taken = 1; branch_target = 32'h101;
        step(); chk("mis_pend_hold", {31'b0, misaligned}, 32'h0);
        idle();
        step(); chk("mis_pend_pc", pc, 32'h80);
        chk("mis_pend_flag", {31'b0, misaligned}, 32'h1);

        // Wrap-around
        jump = 1; jump_address = 32'hFFFF_FFFC;
        step(); chk("wrap_top", pc, 32'hFFFF_FFFC);
        chk("wrap_inc", pc_plus_inc, 32'h0);
        idle();
        step(); chk("wrap_pc", pc, 32'h0);

        // Reset mid-stall discards pending redirect
        stall = 1; jump = 1; jump_address = 32'h500;
        step(); chk("rst2_pend_set", {31'b0, redirect_pending}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_pend", {31'b0, redirect_pending}, 32'h0);
        idle();
        @(negedge clock);
        reset_n = 1'b1;
        step(); chk("rst2_first", pc, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC and target width in bits (minimum 8).
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0080, PC value loaded on exception or misaligned target.
REQ-004 Parameter INC, default 4, sequential increment.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 stall  input  1  hold PC this cycle.
REQ-008 branch_taken  input  1  branch redirect request.
REQ-009 branch_target  input  WIDTH  branch destination.
REQ-010 jump  input  1  jump redirect request.
REQ-011 jump_address  input  WIDTH  jump destination.
REQ-012 jr  input  1  register-jump redirect request.
REQ-013 jr_target  input  WIDTH  register-jump destination.
REQ-014 exception  input  1  exception request.
REQ-015 pc  output  WIDTH  current PC, registered.
REQ-016 pc_plus_inc  output  WIDTH  combinational pc + INC, modulo 2^WIDTH.
REQ-017 redirect_pending  output  1  a redirect captured during stall awaits application.
REQ-018 misaligned  output  1  registered one-cycle pulse: misaligned target was replaced.

Function
REQ-019 Live-request priority SHALL be: exception > jr > jump > branch_taken > sequential.
REQ-020 With stall=0 and no exception, the next pc SHALL be the highest-priority target among live requests and the pending redirect; a live redirect SHALL beat a pending one; with neither, pc SHALL become pc_plus_inc.
REQ-021 Redirect latency SHALL be one cycle: a request sampled at edge N appears on pc after edge N.
REQ-022 With stall=1 and no exception, pc SHALL hold its value.
REQ-023 A jr/jump/branch request during stall SHALL be captured into the pending register; a later request during the same stall SHALL replace it only if of equal or higher priority.
REQ-024 The pending register SHALL be consumed and cleared on the first cycle with stall=0; redirect_pending SHALL equal its valid bit.
REQ-025 exception SHALL override stall: pc becomes EXC_VECTOR on the next edge and the pending register is cleared.
REQ-026 A selected jr/jump/branch target with bits [1:0] non-zero SHALL be replaced by EXC_VECTOR, and misaligned SHALL be 1 for exactly the following cycle; the check SHALL apply whether the target is live or pending.
REQ-027 Sequential increment SHALL wrap modulo 2^WIDTH without any flag.

Reset
REQ-028 While reset_n=0: pc=RESET_VECTOR, pending register cleared, redirect_pending=0, misaligned=0, regardless of clock.
REQ-029 Reset asserted mid-stall with a pending redirect SHALL discard the redirect; the first edge after release SHALL yield pc=RESET_VECTOR+INC unless a live request is present.

Structure
REQ-030 Package pc_pkg SHALL hold the redirect-source enum (SRC_SEQ, SRC_BR, SRC_J, SRC_JR, SRC_EXC), its priority ordering, and default vector constants.
REQ-031 The pending-redirect capture/replace logic SHALL be a sub-module pc_redirect_latch (inputs: stall, source, target; outputs: valid, source, target).

Verification
REQ-032 Reset release, no requests, 3 edges -> pc 0x0, 0x4, 0x8, 0xC.
REQ-033 pc=0x10, jump=1 jump_address=1012 with branch_taken=1 branch_target=44 -> next pc=1012.
REQ-034 stall=1 for 3 cycles, jump=1012 in cycle 1, branch 44 in cycle 2 -> pc held, redirect_pending=1, after stall drops pc=1012.
REQ-035 stall=1 with pending jump, then exception=1 -> pc=0x80 next edge, redirect_pending=0.
REQ-036 jr=1 jr_target=0x1002 -> pc=0x80, misaligned=1 for one cycle.
REQ-037 pc forced to 0xFFFF_FFFC, no requests -> next pc=0x0000_0000.
